// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter with a DEPTH-entry byte FIFO in front.
// The FIFO count excludes the frame currently on the line, so the block holds
// DEPTH queued bytes plus one byte in flight.
module uart_tx_buffered #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                     sysclk,
  input  logic                     reset_n,
  input  logic [7:0]               TX_DATA,
  input  logic                     TX_VALID,
  output logic                     TX_READY,
  output logic                     UART_TX,
  output logic                     TX_BUSY,
  output logic [$clog2(DEPTH):0]   FIFO_COUNT
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic            bit_end;
  logic            fifo_nonempty;

  assign TX_READY      = (count_q < DEPTH_C);
  assign FIFO_COUNT    = count_q;
  assign UART_TX       = tx_q;
  assign TX_BUSY       = (state_q != S_IDLE);

  assign push          = TX_VALID && TX_READY;
  assign bit_end       = (baud_q == DIV_LAST);
  assign fifo_nonempty = (count_q != '0);

  // FIFO storage: written on accepted enqueue; contents need no reset.
  always_ff @(posedge sysclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= TX_DATA;
    end
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM: sequences start/data/stop bits, popping the FIFO when a frame begins.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (fifo_nonempty) begin
            // Chain straight into the next start bit with no idle gap.
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level is decoded from the next state so UART_TX is a flop aligned with the state change.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State, datapath and FIFO control registers with asynchronous reset.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed bench with a byte scoreboard fed on enqueue
// and drained by a mid-bit sampling receiver on UART_TX.
module tb_uart_tx_buffered;

  localparam int unsigned DIV   = 16;
  localparam int unsigned DEPTH = 8;

  logic       sysclk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic       UART_TX;
  logic       TX_BUSY;
  logic [3:0] FIFO_COUNT;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  bit         rx_en = 1'b0;

  uart_tx_buffered #(
    .CLK_FREQ (16),
    .BAUD     (1),
    .DEPTH    (DEPTH)
  ) dut (
    .sysclk     (sysclk),
    .reset_n    (reset_n),
    .TX_DATA    (TX_DATA),
    .TX_VALID   (TX_VALID),
    .TX_READY   (TX_READY),
    .UART_TX    (UART_TX),
    .TX_BUSY    (TX_BUSY),
    .FIFO_COUNT (FIFO_COUNT)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sysclk);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((TX_BUSY !== 1'b0 || FIFO_COUNT !== 4'd0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", (n < budget), 1);
    repeat (4) tick();
  endtask

  // Reference receiver: detect start, sample each bit near its middle, compare against scoreboard.
  initial begin
    logic [7:0] rxb;
    logic [7:0] exp_b;
    forever begin
      tick();
      if (rx_en && UART_TX === 1'b0) begin
        repeat (DIV / 2 - 1) tick();
        chk("rx_start", UART_TX, 0);
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) tick();
          rxb[k] = UART_TX;
        end
        repeat (DIV) tick();
        chk("rx_stop", UART_TX, 1);
        chk("rx_expected_frame", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_b = sb.pop_front();
          chk("rx_byte", rxb, exp_b);
        end
      end
    end
  end

  initial begin
    logic [9:0] frame;
    logic [7:0] nb;
    int         acc;
    int         w;
    int         lows;
    int         g;

    // Asynchronous reset, observed before any clock edge.
    #1 reset_n = 1'b0;
    #2;
    chk("rst_line", UART_TX, 1);
    chk("rst_busy", TX_BUSY, 0);
    chk("rst_count", FIFO_COUNT, 0);
    chk("rst_ready", TX_READY, 1);
    repeat (2) tick();
    reset_n = 1'b1;
    rx_en   = 1'b1;

    // Single byte 0xA5, exact per-cycle line shape.
    tick();
    TX_DATA  = 8'hA5;
    TX_VALID = 1'b1;
    sb.push_back(8'hA5);
    tick();
    TX_VALID = 1'b0;
    chk("a5_queued_count", FIFO_COUNT, 1);
    chk("a5_not_busy_yet", TX_BUSY, 0);
    chk("a5_line_idle", UART_TX, 1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 160; i++) begin
      tick();
      chk("a5_line", UART_TX, frame[i / 16]);
      chk("a5_busy", TX_BUSY, 1);
    end
    tick();
    chk("a5_done_busy", TX_BUSY, 0);
    chk("a5_done_line", UART_TX, 1);
    chk("a5_done_count", FIFO_COUNT, 0);
    wait_idle(50);

    // Back-to-back 0x00 then 0xFF: count 1 -> 0 -> 1 -> 0, no gap between frames.
    tick();
    TX_DATA  = 8'h00;
    TX_VALID = 1'b1;
    sb.push_back(8'h00);
    tick();
    TX_VALID = 1'b0;
    chk("b2b_cnt_a", FIFO_COUNT, 1);
    tick();
    chk("b2b_cnt_b", FIFO_COUNT, 0);
    chk("b2b_start0", UART_TX, 0);
    TX_DATA  = 8'hFF;
    TX_VALID = 1'b1;
    sb.push_back(8'hFF);
    tick();
    TX_VALID = 1'b0;
    chk("b2b_cnt_c", FIFO_COUNT, 1);
    for (int i = 2; i < 320; i++) begin
      tick();
      chk("b2b_busy", TX_BUSY, 1);
      if (i == 159) begin
        chk("b2b_stop1_line", UART_TX, 1);
        chk("b2b_stop1_cnt", FIFO_COUNT, 1);
      end
      if (i == 160) begin
        chk("b2b_start2_line", UART_TX, 0);
        chk("b2b_cnt_d", FIFO_COUNT, 0);
      end
    end
    tick();
    chk("b2b_done_busy", TX_BUSY, 0);
    chk("b2b_done_line", UART_TX, 1);
    wait_idle(50);

    // Simultaneous push and pop with one entry queued.
    tick();
    TX_DATA  = 8'h3C;
    TX_VALID = 1'b1;
    sb.push_back(8'h3C);
    tick();
    chk("pp_cnt_before", FIFO_COUNT, 1);
    chk("pp_idle_before", TX_BUSY, 0);
    TX_DATA = 8'hC3;
    sb.push_back(8'hC3);
    tick();
    TX_VALID = 1'b0;
    chk("pp_cnt_after", FIFO_COUNT, 1);
    chk("pp_busy_after", TX_BUSY, 1);
    wait_idle(400);

    // Fill: hold TX_VALID high until TX_READY drops, then watch it reopen.
    nb  = 8'h40;
    acc = 0;
    tick();
    TX_VALID = 1'b1;
    for (int n = 0; n < 100 && TX_READY === 1'b1; n++) begin
      TX_DATA = nb;
      sb.push_back(nb);
      nb++;
      acc++;
      tick();
    end
    chk("full_accepted", acc, 9);
    chk("full_count", FIFO_COUNT, DEPTH);
    chk("full_busy", TX_BUSY, 1);
    TX_DATA = 8'hEE;
    w = 0;
    while (TX_READY !== 1'b1 && w < 200) begin
      chk("full_hold_count", FIFO_COUNT, DEPTH);
      tick();
      w++;
    end
    chk("full_reopen_timeout", (w < 200), 1);
    chk("full_reopen_count", FIFO_COUNT, DEPTH - 1);
    chk("full_reopen_line", UART_TX, 0);
    sb.push_back(8'hEE);
    tick();
    TX_VALID = 1'b0;
    chk("full_refill_count", FIFO_COUNT, DEPTH);
    wait_idle(3000);

    // Reset during data bit 3 with a second byte queued.
    rx_en = 1'b0;
    tick();
    TX_DATA  = 8'h52;
    TX_VALID = 1'b1;
    tick();
    TX_DATA = 8'h11;
    tick();
    TX_VALID = 1'b0;
    repeat (70) tick();
    chk("rst_mid_busy", TX_BUSY, 1);
    chk("rst_mid_bit3", UART_TX, 0);
    chk("rst_mid_count", FIFO_COUNT, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_line", UART_TX, 1);
    chk("rst_async_busy", TX_BUSY, 0);
    chk("rst_async_count", FIFO_COUNT, 0);
    chk("rst_async_ready", TX_READY, 1);
    repeat (2) tick();
    reset_n = 1'b1;
    lows = 0;
    repeat (400) begin
      tick();
      if (UART_TX !== 1'b1 || TX_BUSY !== 1'b0) lows++;
    end
    chk("post_reset_quiet", lows, 0);
    chk("post_reset_count", FIFO_COUNT, 0);
    rx_en = 1'b1;
    tick();
    TX_DATA  = 8'h81;
    TX_VALID = 1'b1;
    sb.push_back(8'h81);
    tick();
    TX_VALID = 1'b0;
    wait_idle(400);

    // All 256 byte values through the reference receiver.
    for (int b = 0; b < 256; b++) begin
      TX_DATA  = 8'(b);
      TX_VALID = 1'b1;
      g = 0;
      while (TX_READY !== 1'b1 && g < 400) begin
        tick();
        g++;
      end
      chk("sweep_ready_timeout", (g < 400), 1);
      sb.push_back(8'(b));
      tick();
    end
    TX_VALID = 1'b0;
    wait_idle(256 * 160 + 1000);
    repeat (20) tick();
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate in bit/s.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-004 SHALL have port sysclk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port TX_DATA, input, 8, byte to enqueue.
REQ-007 SHALL have port TX_VALID, input, 1, enqueue request.
REQ-008 SHALL have port TX_READY, output, 1, FIFO can accept a byte.
REQ-009 SHALL have port UART_TX, output, 1, serial line, idle high.
REQ-010 SHALL have port TX_BUSY, output, 1, a frame is being shifted out.
REQ-011 SHALL have port FIFO_COUNT, output, log2(DEPTH)+1, bytes queued, excluding the frame in flight.

Function
REQ-012 SHALL derive bit period DIV = CLK_FREQ/BAUD (integer division) sysclk cycles; every bit, including start and stop, holds UART_TX for exactly DIV cycles.
REQ-013 SHALL enqueue TX_DATA on a rising edge where TX_VALID=1 and TX_READY=1; no enqueue occurs otherwise, and TX_DATA is ignored.
REQ-014 SHALL drive TX_READY = (FIFO_COUNT < DEPTH), from registered state only, with no combinational path from TX_VALID.
REQ-015 SHALL use a state machine with states IDLE, START, DATA and STOP.
REQ-016 In IDLE with FIFO_COUNT > 0, SHALL pop the head byte into the shift register and enter START on the same edge; UART_TX falls on the following cycle.
REQ-017 START SHALL drive 0 for DIV cycles and then enter DATA with the bit index at 0.
REQ-018 DATA SHALL send 8 bits LSB first, each for DIV cycles; after bit 7 it SHALL enter STOP.
REQ-019 STOP SHALL drive 1 for DIV cycles; at its end it SHALL return to IDLE, or, if the FIFO is non-empty, pop and enter START directly with no idle bit between frames.
REQ-020 SHALL drive UART_TX high in IDLE and STOP, low in START, and from the shift register LSB in DATA; UART_TX SHALL be registered.
REQ-021 SHALL assert TX_BUSY in START, DATA and STOP, and deassert it in IDLE.
REQ-022 On a simultaneous enqueue and pop, SHALL leave FIFO_COUNT unchanged and order the bytes correctly, including when the FIFO holds exactly one entry.
REQ-023 When full, TX_READY=0, so an enqueue on the same edge as a pop SHALL NOT occur; TX_READY rises one cycle after the pop.
REQ-024 SHALL wrap read and write pointers modulo DEPTH; order SHALL be strict FIFO.
REQ-025 The baud counter SHALL restart at 0 on every state entry, so each bit is aligned to the state change.

Reset
REQ-026 On reset_n=0, SHALL immediately and asynchronously set: state IDLE, UART_TX=1, TX_BUSY=0, FIFO_COUNT=0, TX_READY=1, pointers, bit index and baud counter to 0.
REQ-027 Reset mid-frame SHALL abort the frame and discard all queued bytes; after release, no transmission starts until a new enqueue.
REQ-028 SHALL begin operating on the first rising edge after reset_n deasserts.

Verification
REQ-029 Single byte (CLK_FREQ=16, BAUD=1, DIV=16): enqueue 0xA5 -> UART_TX emits 0,1,0,1,0,0,1,0,1,1, each for 16 cycles; TX_BUSY high for 160 cycles, then IDLE.
REQ-030 Back-to-back: enqueue 0x00 then 0xFF -> second start bit immediately follows the first stop bit (320 cycles of frames, no gap); FIFO_COUNT goes 1 -> 0 -> 1 -> 0.
REQ-031 Full: hold TX_VALID=1 with DIV=16, DEPTH=8 -> 9 bytes accepted (1 in flight + 8 queued), then TX_READY=0; after the next pop, TX_READY=1 one cycle later; all 9 bytes arrive in order.
REQ-032 Simultaneous push/pop at FIFO_COUNT=1 -> count stays 1 and byte order is preserved.
REQ-033 Assert reset_n=0 during data bit 3 -> UART_TX=1, TX_BUSY=0, FIFO_COUNT=0 with no clock edge needed; no frame after release.
REQ-034 Line check: a reference UART receiver model sampling mid-bit decodes all 256 byte values sent in sequence without error.
